// File: rtl/canny_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : canny_pkg
//  Description : Shared types, widths and helpers for the Canny frame
//                sequencer (state encoding, counter widths, reset frame size).
//  Revision    : 1.0 - initial release
// ============================================================================
package canny_pkg;

  localparam int DIM_W     = 16;  // width/height field width
  localparam int PIX_CNT_W = 20;  // pixels per frame, max 1280*720 = 921600
  localparam int WDOG_W    = 16;  // drain watchdog idle counter width

  localparam logic [DIM_W-1:0] RST_WIDTH  = 16'd640;
  localparam logic [DIM_W-1:0] RST_HEIGHT = 16'd480;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CTRL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } seq_state_e;

  // A zero dimension means "use the largest supported size"; anything above
  // the supported size is clamped to it.
  function automatic logic [DIM_W-1:0] clamp_dim(input logic [DIM_W-1:0] dim,
                                                 input logic [DIM_W-1:0] max_dim);
    if ((dim == '0) || (dim > max_dim)) begin
      return max_dim;
    end
    return dim;
  endfunction

endpackage
`default_nettype wire

// File: rtl/canny_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : canny_frame_sequencer_if
//  Description : Control-packet and pixel-stream handshake bundle between the
//                frame sequencer (master) and its surroundings (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface canny_frame_sequencer_if;
  import canny_pkg::*;

  // control packet decoder / encoder
  logic             vip_ctrl_valid;
  logic [DIM_W-1:0] width_in;
  logic [DIM_W-1:0] height_in;
  logic             vip_ctrl_busy;
  logic             vip_ctrl_send;
  logic [DIM_W-1:0] width_out;
  logic [DIM_W-1:0] height_out;

  // upstream beats into the Canny pipeline
  logic             in_valid;
  logic             in_ready;
  logic             pipe_full;
  logic             pipe_wr_en;

  // pipeline output towards downstream
  logic             pipe_empty;
  logic             pipe_rd_en;
  logic             out_stall;
  logic             out_valid;
  logic             out_eop;

  modport master (
    input  vip_ctrl_valid, width_in, height_in, vip_ctrl_busy,
    input  in_valid, pipe_full, pipe_empty, out_stall,
    output vip_ctrl_send, width_out, height_out,
    output in_ready, pipe_wr_en, pipe_rd_en, out_valid, out_eop
  );

  modport slave (
    output vip_ctrl_valid, width_in, height_in, vip_ctrl_busy,
    output in_valid, pipe_full, pipe_empty, out_stall,
    input  vip_ctrl_send, width_out, height_out,
    input  in_ready, pipe_wr_en, pipe_rd_en, out_valid, out_eop
  );

endinterface
`default_nettype wire

// File: rtl/canny_seq_counter.sv
`default_nettype none
// ============================================================================
//  Module      : canny_seq_counter
//  Description : Clearable up-counter with terminal-count compare. Reports
//                whether the count is still below the terminal value and
//                whether it sits on the last value before it.
//  Revision    : 1.0 - initial release
// ============================================================================
module canny_seq_counter
  import canny_pkg::*;
#(
  parameter int W = PIX_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         below,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear has priority so a frame ending on an increment restarts at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign below = (cnt_q < term);
  assign last  = (cnt_q == (term - W'(1)));

endmodule
`default_nettype wire

// File: rtl/canny_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : canny_frame_sequencer
//  Description : Frame-level sequencer around a Canny edge pipeline. Latches
//                the frame size from a control packet, forwards it to the
//                control encoder, meters width*height beats into the pipeline
//                and the same number out, flagging end-of-packet and frame
//                completion. Control packets arriving mid-frame are held in a
//                shadow register and applied at the next frame boundary.
//  Options     : CANNY_SEQ_WATCHDOG_EN - drain watchdog; after 65535 idle
//                cycles in DRAIN the frame is abandoned and err is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module canny_frame_sequencer
  import canny_pkg::*;
#(
  parameter int MAX_WIDTH  = 1280,
  parameter int MAX_HEIGHT = 720
) (
  input  logic                     clk,
  input  logic                     rst,
  canny_frame_sequencer_if.master  bus,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     err
);

  localparam logic [DIM_W-1:0] MAX_W_C = DIM_W'(MAX_WIDTH);
  localparam logic [DIM_W-1:0] MAX_H_C = DIM_W'(MAX_HEIGHT);

  seq_state_e           state_q,      state_d;
  logic [DIM_W-1:0]     width_q,      width_d;
  logic [DIM_W-1:0]     height_q,     height_d;
  logic [PIX_CNT_W-1:0] total_q,      total_d;
  logic [DIM_W-1:0]     shadow_w_q,   shadow_w_d;
  logic [DIM_W-1:0]     shadow_h_q,   shadow_h_d;
  logic                 pending_q,    pending_d;
  logic [DIM_W-1:0]     width_out_q,  width_out_d;
  logic [DIM_W-1:0]     height_out_q, height_out_d;

  logic [DIM_W-1:0]     src_w, src_h;
  logic [DIM_W-1:0]     clamp_w, clamp_h;
  logic                 ctrl_send;
  logic                 in_ready;
  logic                 wr_fire;
  logic                 out_fire;
  logic                 frame_end;
  logic                 wdog_expire;
  logic                 in_below, in_last;
  logic                 out_below, out_last;

  // A live control packet always beats a stored one.
  assign src_w   = bus.vip_ctrl_valid ? bus.width_in  : shadow_w_q;
  assign src_h   = bus.vip_ctrl_valid ? bus.height_in : shadow_h_q;
  assign clamp_w = clamp_dim(src_w, MAX_W_C);
  assign clamp_h = clamp_dim(src_h, MAX_H_C);

  assign ctrl_send = (state_q == ST_CTRL) & ~bus.vip_ctrl_busy;
  assign in_ready  = (state_q == ST_STREAM) & ~bus.pipe_full & in_below;
  assign wr_fire   = bus.in_valid & in_ready;
  assign out_fire  = ((state_q == ST_STREAM) | (state_q == ST_DRAIN))
                   & ~bus.pipe_empty & ~bus.out_stall & out_below;
  assign frame_end = (out_fire & out_last) | wdog_expire;

  canny_seq_counter #(.W(PIX_CNT_W)) u_in_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (frame_end),
    .inc   (wr_fire),
    .term  (total_q),
    .below (in_below),
    .last  (in_last)
  );

  canny_seq_counter #(.W(PIX_CNT_W)) u_out_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (frame_end),
    .inc   (out_fire),
    .term  (total_q),
    .below (out_below),
    .last  (out_last)
  );

`ifdef CANNY_SEQ_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              err_q,  err_d;

  // Count consecutive DRAIN cycles without an output read; expire at all-ones.
  always_comb begin
    wdog_d      = '0;
    err_d       = err_q;
    wdog_expire = 1'b0;
    if ((state_q == ST_DRAIN) && !out_fire) begin
      if (wdog_q == '1) begin
        wdog_expire = 1'b1;
        err_d       = 1'b1;
      end else begin
        wdog_d = wdog_q + WDOG_W'(1);
      end
    end
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign wdog_expire = 1'b0;
  assign err         = 1'b0;
`endif

  // Next-state, frame-size latching and shadow capture.
  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    height_d     = height_q;
    total_d      = total_q;
    shadow_w_d   = shadow_w_q;
    shadow_h_d   = shadow_h_q;
    pending_d    = pending_q;
    width_out_d  = width_out_q;
    height_out_d = height_out_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.vip_ctrl_valid || pending_q) begin
          width_d   = clamp_w;
          height_d  = clamp_h;
          total_d   = PIX_CNT_W'(clamp_w) * PIX_CNT_W'(clamp_h);
          pending_d = 1'b0;
          state_d   = ST_CTRL;
        end
      end
      ST_CTRL: begin
        if (ctrl_send) begin
          width_out_d  = width_q;
          height_out_d = height_q;
          state_d      = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (frame_end) begin
          state_d = ST_IDLE;
        end else if (wr_fire && in_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (frame_end) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Packets seen mid-frame are parked; the newest one wins.
    if ((state_q != ST_IDLE) && bus.vip_ctrl_valid) begin
      shadow_w_d = bus.width_in;
      shadow_h_d = bus.height_in;
      pending_d  = 1'b1;
    end
  end

  // State and frame-size registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      width_q      <= RST_WIDTH;
      height_q     <= RST_HEIGHT;
      total_q      <= '0;
      shadow_w_q   <= '0;
      shadow_h_q   <= '0;
      pending_q    <= 1'b0;
      width_out_q  <= RST_WIDTH;
      height_out_q <= RST_HEIGHT;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      height_q     <= height_d;
      total_q      <= total_d;
      shadow_w_q   <= shadow_w_d;
      shadow_h_q   <= shadow_h_d;
      pending_q    <= pending_d;
      width_out_q  <= width_out_d;
      height_out_q <= height_out_d;
    end
  end

  assign bus.vip_ctrl_send = ctrl_send;
  assign bus.width_out     = width_out_q;
  assign bus.height_out    = height_out_q;
  assign bus.in_ready      = in_ready;
  assign bus.pipe_wr_en    = wr_fire;
  assign bus.pipe_rd_en    = out_fire;
  assign bus.out_valid     = out_fire;
  assign bus.out_eop       = out_fire & out_last;

  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_end;

endmodule
`default_nettype wire

// File: tb/tb_canny_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_canny_frame_sequencer
//  Description : Randomized bench for canny_frame_sequencer with a frame-level
//                reference model (phase, beat tallies, pending packet).
//  Options     : CANNY_SEQ_WATCHDOG_EN - also exercises the drain watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_canny_frame_sequencer;

  localparam int PH_IDLE   = 0;
  localparam int PH_CTRL   = 1;
  localparam int PH_STREAM = 2;
  localparam int MAXW      = 1280;
  localparam int MAXH      = 720;

  logic clk = 1'b0;
  logic rst;
  logic busy, frame_done, err;

  canny_frame_sequencer_if bus ();

  canny_frame_sequencer #(.MAX_WIDTH(MAXW), .MAX_HEIGHT(MAXH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus knobs (percent probabilities)
  int p_valid, p_full, p_empty, p_stall, p_busy, p_ctrl;
  bit stall_alt;
  int busy_cnt;
  bit ctrl_req;
  int ctrl_w, ctrl_h;
  int cyc;

  // reference model
  int m_phase, m_w, m_h, m_total, m_wr, m_rd, m_wd;
  bit m_pend, m_err;
  int m_shw, m_shh, m_wout, m_hout;
  int obs_send, obs_rd, obs_eop;
  int done_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic bit pct(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  function automatic int clampv(input int v, input int mx);
    return (v == 0 || v > mx) ? mx : v;
  endfunction

  task automatic quiet_inputs();
    bus.vip_ctrl_valid = 1'b0;
    bus.width_in       = '0;
    bus.height_in      = '0;
    bus.vip_ctrl_busy  = 1'b0;
    bus.in_valid       = 1'b0;
    bus.pipe_full      = 1'b0;
    bus.pipe_empty     = 1'b1;
    bus.out_stall      = 1'b0;
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE; m_pend = 0; m_err = 0; m_wr = 0; m_rd = 0; m_wd = 0;
    m_wout = 640; m_hout = 480; m_total = 0;
    ctrl_req = 0; busy_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    quiet_inputs();
    #2;
    check_eq("rst_busy",       busy,              0);
    check_eq("rst_send",       bus.vip_ctrl_send, 0);
    check_eq("rst_in_ready",   bus.in_ready,      0);
    check_eq("rst_out_valid",  bus.out_valid,     0);
    check_eq("rst_eop",        bus.out_eop,       0);
    check_eq("rst_frame_done", frame_done,        0);
    check_eq("rst_width_out",  bus.width_out,     640);
    check_eq("rst_height_out", bus.height_out,    480);
    check_eq("rst_err",        err,               0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Compare this cycle's outputs with the model, then advance the model to
  // what the next clock edge commits.
  task automatic model_check();
    bit exp_send, exp_ir, exp_rv, exp_eop, exp_done, expire;
    int ph;
    exp_send = 0; exp_ir = 0; exp_rv = 0; exp_eop = 0; exp_done = 0; expire = 0;
    ph = m_phase;
    if (ph == PH_CTRL) exp_send = !bus.vip_ctrl_busy;
    if (ph == PH_STREAM) begin
      exp_ir   = !bus.pipe_full && (m_wr < m_total);
      exp_rv   = !bus.pipe_empty && !bus.out_stall && (m_rd < m_total);
      exp_eop  = exp_rv && (m_rd == m_total - 1);
      exp_done = exp_eop;
`ifdef CANNY_SEQ_WATCHDOG_EN
      if (m_wr == m_total && !exp_rv && m_wd == 65535) begin
        expire = 1; exp_done = 1;
      end
`endif
    end
    check_eq("busy",       busy,              ph != PH_IDLE);
    check_eq("send",       bus.vip_ctrl_send, exp_send);
    check_eq("in_ready",   bus.in_ready,      exp_ir);
    check_eq("pipe_wr_en", bus.pipe_wr_en,    bus.in_valid & exp_ir);
    check_eq("out_valid",  bus.out_valid,     exp_rv);
    check_eq("pipe_rd_en", bus.pipe_rd_en,    exp_rv);
    check_eq("out_eop",    bus.out_eop,       exp_eop);
    check_eq("frame_done", frame_done,        exp_done);
    check_eq("width_out",  bus.width_out,     m_wout);
    check_eq("height_out", bus.height_out,    m_hout);
    check_eq("err",        err,               m_err);

    if (bus.vip_ctrl_send) obs_send++;
    if (bus.out_valid)     obs_rd++;
    if (bus.out_eop)       obs_eop++;

    if (ph == PH_IDLE) begin
      if (bus.vip_ctrl_valid || m_pend) begin
        m_w = bus.vip_ctrl_valid ? clampv(int'(bus.width_in),  MAXW) : clampv(m_shw, MAXW);
        m_h = bus.vip_ctrl_valid ? clampv(int'(bus.height_in), MAXH) : clampv(m_shh, MAXH);
        m_total = m_w * m_h;
        m_pend = 0; m_phase = PH_CTRL;
        obs_send = 0; obs_rd = 0; obs_eop = 0;
      end
    end else begin
      if (bus.vip_ctrl_valid) begin
        m_shw = int'(bus.width_in); m_shh = int'(bus.height_in); m_pend = 1;
      end
    end

    if (ph == PH_CTRL && exp_send) begin
      m_wout = m_w; m_hout = m_h; m_wr = 0; m_rd = 0; m_wd = 0;
      m_phase = PH_STREAM;
    end

    if (ph == PH_STREAM) begin
      if (m_wr == m_total && !exp_rv && !expire) m_wd++;
      else m_wd = 0;
      if (bus.in_valid && exp_ir) m_wr++;
      if (exp_rv) m_rd++;
      if (exp_done) begin
        if (!expire) begin
          check_eq("frame_reads", obs_rd,  m_total);
          check_eq("eop_count",   obs_eop, 1);
        end
        check_eq("send_count", obs_send, 1);
        done_q.push_back(m_total);
        if (expire) m_err = 1;
        m_phase = PH_IDLE;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.in_valid   = pct(p_valid);
    bus.pipe_full  = pct(p_full);
    bus.pipe_empty = pct(p_empty);
    bus.out_stall  = stall_alt ? cyc[0] : pct(p_stall);
    if (busy_cnt > 0) begin
      bus.vip_ctrl_busy = 1'b1;
      busy_cnt--;
    end else begin
      bus.vip_ctrl_busy = pct(p_busy);
    end
    if (ctrl_req) begin
      bus.vip_ctrl_valid = 1'b1;
      bus.width_in       = 16'(ctrl_w);
      bus.height_in      = 16'(ctrl_h);
      ctrl_req           = 0;
    end else if (pct(p_ctrl)) begin
      bus.vip_ctrl_valid = 1'b1;
      bus.width_in       = 16'($urandom_range(6, 1));
      bus.height_in      = 16'($urandom_range(6, 1));
    end else begin
      bus.vip_ctrl_valid = 1'b0;
      bus.width_in       = 16'($urandom);
      bus.height_in      = 16'($urandom);
    end
    #4;
    model_check();
    cyc++;
  endtask

  task automatic run_until_idle(input int bound);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(m_phase == PH_IDLE && !m_pend && !ctrl_req) && n < bound);
    check_eq("idle_after_run", (m_phase == PH_IDLE && !m_pend), 1);
  endtask

  task automatic knobs(input int v, input int f, input int e, input int s,
                       input int b, input int c);
    p_valid = v; p_full = f; p_empty = e; p_stall = s; p_busy = b; p_ctrl = c;
  endtask

  task automatic send_ctrl(input int w, input int h);
    ctrl_req = 1; ctrl_w = w; ctrl_h = h;
  endtask

  initial begin
    cyc = 0; stall_alt = 0;
    knobs(0, 0, 100, 0, 0, 0);
    do_reset();

    // 4x2 frame, pipeline never full or empty
    knobs(100, 0, 0, 0, 0, 0);
    send_ctrl(4, 2);
    run_until_idle(200);
    check_eq("t1_total", done_q[done_q.size()-1], 8);

    // encoder busy for five cycles in CTRL
    send_ctrl(4, 2);
    busy_cnt = 6;
    run_until_idle(200);

    // downstream stall every other cycle
    stall_alt = 1;
    send_ctrl(4, 2);
    run_until_idle(200);
    stall_alt = 0;

    // new packet mid-stream applies to the following frame
    knobs(100, 0, 30, 0, 0, 0);
    send_ctrl(4, 2);
    repeat (3) step();
    send_ctrl(8, 8);
    run_until_idle(1000);
    check_eq("t4_first_total",  done_q[done_q.size()-2], 8);
    check_eq("t4_second_total", done_q[done_q.size()-1], 64);
    check_eq("t4_width_out",    bus.width_out, 8);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      knobs($urandom_range(100, 30), $urandom_range(50, 0), $urandom_range(60, 0),
            $urandom_range(50, 0), $urandom_range(70, 0), $urandom_range(3, 0));
      send_ctrl($urandom_range(6, 1), $urandom_range(6, 1));
      run_until_idle(4000);
    end

    // zero width and oversized height clamp to the maximum, then reset mid-frame
    knobs(100, 0, 50, 0, 0, 0);
    send_ctrl(0, 2000);
    repeat (30) step();
    check_eq("clamp_width_out",  bus.width_out,  MAXW);
    check_eq("clamp_height_out", bus.height_out, MAXH);
    check_eq("clamp_in_ready",   bus.in_ready,   1);
    do_reset();
    repeat (5) step();

    // pipeline output never becomes non-empty while draining
    knobs(100, 0, 100, 0, 0, 0);
    send_ctrl(2, 2);
    repeat (300) step();
    check_eq("drain_stuck_busy", busy, 1);
`ifdef CANNY_SEQ_WATCHDOG_EN
    run_until_idle(70000);
    check_eq("wdog_err", err, 1);
`endif
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/canny_frame_sequencer.md
CANNY_FRAME_SEQUENCER -- requirements
Module: canny_frame_sequencer

Interface
REQ-001 Parameter MAX_WIDTH, 1280, largest accepted frame width in pixels.
REQ-002 Parameter MAX_HEIGHT, 720, largest accepted frame height in pixels.
REQ-003 clk  in  1  clock; single clock domain, rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 vip_ctrl_valid  in  1  decoded control packet present this cycle.
REQ-006 width_in / height_in  in  16 each  frame size from control packet.
REQ-007 vip_ctrl_busy  in  1  control encoder cannot accept a send.
REQ-008 vip_ctrl_send  out  1  one-cycle request to emit output control packet.
REQ-009 width_out / height_out  out  16 each  frame size forwarded to encoder.
REQ-010 in_valid  in  1  upstream beat offered (not stalled).
REQ-011 in_ready  out  1  sequencer accepts an upstream beat (drives read).
REQ-012 pipe_full  in  1  Canny pipeline input FIFO full.
REQ-013 pipe_wr_en  out  1  write accepted beat into pipeline.
REQ-014 pipe_empty  in  1  pipeline output FIFO (first-word-fall-through) empty.
REQ-015 pipe_rd_en  out  1  pop pipeline output.
REQ-016 out_stall  in  1  downstream stall.
REQ-017 out_valid  out  1  output beat valid this cycle.
REQ-018 out_eop  out  1  end-of-video, qualifies last out_valid beat of frame.
REQ-019 busy  out  1  state is not IDLE.
REQ-020 frame_done  out  1  one-cycle pulse when final output pixel leaves.
REQ-021 err  out  1  sticky watchdog error flag.

Function
REQ-022 States IDLE, CTRL, STREAM, DRAIN; frame total = width*height, 20-bit unsigned (max 921600).
REQ-023 IDLE: on vip_ctrl_valid, or pending flag set, latch dims (clamped to MAX_*; zero value replaced by MAX_*), register total, go CTRL next cycle.
REQ-024 CTRL: vip_ctrl_send=1 for exactly one cycle in which vip_ctrl_busy=0, width_out/height_out updated same edge; then STREAM.
REQ-025 STREAM: in_ready = ~pipe_full & (in_cnt < total); pipe_wr_en = in_valid & in_ready; in_cnt increments per write.
REQ-026 STREAM and DRAIN: pipe_rd_en = out_valid = ~pipe_empty & ~out_stall & (out_cnt < total); out_cnt increments per read; combinational, zero latency.
REQ-027 out_eop = out_valid & (out_cnt == total-1).
REQ-028 STREAM -> DRAIN on the cycle in_cnt reaches total; in_ready=0 in DRAIN, CTRL, IDLE.
REQ-029 DRAIN (or STREAM) -> IDLE when out_cnt reaches total; frame_done pulses that cycle; both counters cleared.
REQ-030 vip_ctrl_valid outside IDLE: dims stored in shadow register, pending flag set; applied at next IDLE; later packets overwrite shadow.
REQ-031 vip_ctrl_valid in IDLE same cycle as pending: live input wins, pending cleared.
REQ-032 Final input write and final output read in same cycle: go directly STREAM -> IDLE, frame_done pulses.

Reset
REQ-033 Reset: state IDLE, counters 0, pending 0, err 0, width_out=640, height_out=480, all strobes/handshake outputs 0.
REQ-034 Reset mid-frame abandons frame; no out_eop or frame_done generated.

Configuration
REQ-035 Macro CANNY_SEQ_WATCHDOG_EN defined: 16-bit idle counter in DRAIN, cleared on each output read; at 65535 forces IDLE, frame_done pulse, err=1 until reset.
REQ-036 Macro undefined: no watchdog logic, err tied 0, DRAIN waits indefinitely.

Structure
REQ-037 Shared package canny_pkg holds state enum, PIX_CNT_W=20, reset dims 640/480, WDOG_W=16.
REQ-038 One sub-module canny_seq_counter (clearable up-counter with terminal-count compare), instantiated for in_cnt and out_cnt.

Verification
REQ-039 ctrl 4x2, in_valid=1, pipe never full/empty -> 8 writes, 8 reads, out_eop on 8th read, frame_done once, back to IDLE.
REQ-040 vip_ctrl_busy high 5 cycles in CTRL -> vip_ctrl_send asserted once, first cycle busy=0.
REQ-041 4x2, out_stall pulsed every other cycle -> out_valid never high with out_stall, exactly 8 reads, eop on last.
REQ-042 ctrl 8x8 during STREAM of 4x2 frame -> current frame ends at 8 pixels; next frame totals 64.
REQ-043 width_in=0, height_in=2000 -> total 1280*720=921600.
REQ-044 With CANNY_SEQ_WATCHDOG_EN, pipe_empty stuck high in DRAIN -> after 65535 cycles frame_done, err=1, IDLE; without macro, stays DRAIN.
